trigger_qualifier: RTL and testbench

Programmable trigger-condition stage directly upstream of the internal logic analyzer. It watches the probed data bus and compares it against a masked pattern, with optional per-bit edge qualification and a required run length of consecutive matches. It emits a single-cycle trigger pulse into the analyzer's trigger input, with the probed data re-timed so the analyzer captures the matching sample in the same cycle as the trigger. Triggers are suppressed until the analyzer reports itself primed.

---
 rtl/trigger_qualifier.sv | 121 ++++++++++++
 tb/tb_trigger_qualifier.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/trigger_qualifier.sv
// Masked-pattern trigger qualifier with run-length counting, feeding the logic analyzer.
// Define TRIGGER_EDGE_EN to build per-bit edge qualification (adds the s2 history register).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module trigger_qualifier #(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_mask,
    input  logic [DATA_WIDTH-1:0] i_pattern,
    input  logic [DATA_WIDTH-1:0] i_edge_mask,
    input  logic [CNT_WIDTH-1:0]  i_match_count,
    input  logic                  i_arm,
    input  logic                  i_primed,
    output logic                  o_trigger,
    output logic                  o_armed,
    output logic [DATA_WIDTH-1:0] o_data
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FIRED
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] s1;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  tgt;
    logic                  lvl_ok;
    logic                  edge_ok;
    logic                  match;
    logic                  fire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1     <= '0;
            o_data <= '0;
        end else begin
            s1     <= i_data;
            o_data <= s1;
        end
    end

`ifdef TRIGGER_EDGE_EN
    logic [DATA_WIDTH-1:0] s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2 <= '0;
        end else begin
            s2 <= s1;
        end
    end

    assign edge_ok = ((s1 ^ s2) & i_edge_mask) == i_edge_mask;
`else
    logic edge_mask_unused;

    assign edge_mask_unused = ^i_edge_mask;
    assign edge_ok          = 1'b1;
`endif

    assign lvl_ok = ((s1 ^ i_pattern) & i_mask) == '0;
    assign match  = lvl_ok & edge_ok;
    assign tgt    = (i_match_count == '0) ? CNT_WIDTH'(1) : i_match_count;
    // The completing match is counted by the fire itself, hence tgt-1 prior matches.
    assign fire   = (state == ARMED) & i_primed & match & i_arm
                  & (cnt >= (tgt - CNT_WIDTH'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            o_trigger <= 1'b0;
        end else begin
            o_trigger <= fire;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (i_arm) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (!i_arm) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (fire) begin
                        state <= FIRED;
                        cnt   <= '0;
                    end else if (match && i_primed) begin
                        if (cnt != '1) begin
                            cnt <= cnt + CNT_WIDTH'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                FIRED: begin
                    cnt <= '0;
                    if (!i_arm) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign o_armed = (state == ARMED);

endmodule

// File: tb/tb_trigger_qualifier.sv
// Directed bench for trigger_qualifier; edge-test expectations follow TRIGGER_EDGE_EN.
`timescale 1ns/1ps

module tb_trigger_qualifier;

    logic       clk;
    logic       reset;
    logic [7:0] i_data;
    logic [7:0] i_mask;
    logic [7:0] i_pattern;
    logic [7:0] i_edge_mask;
    logic [7:0] i_match_count;
    logic       i_arm;
    logic       i_primed;
    logic       o_trigger;
    logic       o_armed;
    logic [7:0] o_data;

    int errors = 0;
    int checks = 0;

    trigger_qualifier #(
        .DATA_WIDTH(8),
        .CNT_WIDTH (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_data       (i_data),
        .i_mask       (i_mask),
        .i_pattern    (i_pattern),
        .i_edge_mask  (i_edge_mask),
        .i_match_count(i_match_count),
        .i_arm        (i_arm),
        .i_primed     (i_primed),
        .o_trigger    (o_trigger),
        .o_armed      (o_armed),
        .o_data       (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; i_data = '0; i_mask = '0; i_pattern = '0; i_edge_mask = '0;
        i_match_count = '0; i_arm = 1'b0; i_primed = 1'b0;
        tick(); tick();
        checks++; if (o_trigger !== 1'b0) begin errors++; $display("FAIL reset_trigger got=%b exp=0", o_trigger); end
        checks++; if (o_armed !== 1'b0) begin errors++; $display("FAIL reset_armed got=%b exp=0", o_armed); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", o_data); end
        #3 reset = 1'b1;
        tick();
        checks++; if (o_armed !== 1'b0) begin errors++; $display("FAIL reset_idle_armed got=%b exp=0", o_armed); end
    endtask

    task automatic test_single_match();
        i_mask = 8'hFF; i_pattern = 8'hA5; i_edge_mask = 8'h00; i_match_count = 8'd1;
        i_primed = 1'b1; i_data = 8'h00; i_arm = 1'b1;
        tick();
        checks++; if (o_armed !== 1'b1) begin errors++; $display("FAIL single_armed got=%b exp=1", o_armed); end
        i_data = 8'hA5;
        tick();
        checks++; if (o_trigger !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", o_trigger); end
        tick();
        checks++; if (o_trigger !== 1'b1) begin errors++; $display("FAIL single_trigger got=%b exp=1", o_trigger); end
        checks++; if (o_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", o_data); end
        checks++; if (o_armed !== 1'b0) begin errors++; $display("FAIL single_armed_drop got=%b exp=0", o_armed); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_trigger !== 1'b0) begin errors++; $display("FAIL single_repeat[%0d] got=%b exp=0", i, o_trigger); end
        end
    endtask

    task automatic test_run_length();
        logic [7:0] seq [6] = '{8'hA5, 8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hA5};
        i_arm = 1'b0; i_data = 8'h00;
        tick();
        i_match_count = 8'd3; i_arm = 1'b1;
        tick();
        for (int k = 0; k <= 6; k++) begin
            i_data = (k < 6) ? seq[k] : 8'h00;
            tick();
            checks++; if (o_trigger !== (k == 6)) begin errors++; $display("FAIL run_trigger[%0d] got=%b exp=%b", k, o_trigger, (k == 6)); end
            if (k >= 1) begin
                checks++; if (o_data !== seq[k-1]) begin errors++; $display("FAIL run_data[%0d] got=%h exp=%h", k, o_data, seq[k-1]); end
            end
        end
    endtask

    task automatic test_priming();
        i_arm = 1'b0;
        tick();
        i_primed = 1'b0; i_match_count = 8'd2; i_arm = 1'b1; i_data = 8'h00;
        tick();
        for (int k = 0; k <= 6; k++) begin
            i_data   = (k < 6) ? 8'hA5 : 8'h00;
            i_primed = (k >= 4);
            tick();
            checks++; if (o_trigger !== (k == 5)) begin errors++; $display("FAIL prime_trigger[%0d] got=%b exp=%b", k, o_trigger, (k == 5)); end
        end
    endtask

    task automatic test_edge();
        logic [7:0] dv [4] = '{8'h00, 8'h01, 8'h00, 8'h00};
`ifdef TRIGGER_EDGE_EN
        int         fire_k = 2;
        logic [7:0] fire_d = 8'h01;
`else
        int         fire_k = 0;
        logic [7:0] fire_d = 8'h00;
`endif
        i_arm = 1'b0; i_primed = 1'b1; i_data = 8'h00;
        tick(); tick();
        i_mask = 8'h00; i_edge_mask = 8'h01; i_match_count = 8'd1; i_arm = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            i_data = dv[k];
            tick();
            checks++; if (o_trigger !== (k == fire_k)) begin errors++; $display("FAIL edge_trigger[%0d] got=%b exp=%b", k, o_trigger, (k == fire_k)); end
            if (k == fire_k) begin
                checks++; if (o_data !== fire_d) begin errors++; $display("FAIL edge_data got=%h exp=%h", o_data, fire_d); end
            end
        end
    endtask

    task automatic test_reset_mid();
        i_arm = 1'b0;
        tick();
        i_mask = 8'hFF; i_pattern = 8'hA5; i_edge_mask = 8'h00; i_match_count = 8'd5;
        i_primed = 1'b1; i_data = 8'h00; i_arm = 1'b1;
        tick();
        i_data = 8'hA5;
        tick(); tick(); tick();
        checks++; if (o_armed !== 1'b1) begin errors++; $display("FAIL rmid_pre_armed got=%b exp=1", o_armed); end
        checks++; if (o_data !== 8'hA5) begin errors++; $display("FAIL rmid_pre_data got=%h exp=a5", o_data); end
        #2 reset = 1'b0;
        #1;
        checks++; if (o_armed !== 1'b0) begin errors++; $display("FAIL rmid_armed got=%b exp=0", o_armed); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL rmid_data got=%h exp=00", o_data); end
        checks++; if (o_trigger !== 1'b0) begin errors++; $display("FAIL rmid_trigger got=%b exp=0", o_trigger); end
        i_match_count = 8'd3;
        tick();
        #3 reset = 1'b1;
        tick();
        checks++; if (o_armed !== 1'b1) begin errors++; $display("FAIL rmid_rearm got=%b exp=1", o_armed); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (o_trigger !== (k == 3)) begin errors++; $display("FAIL rmid_count[%0d] got=%b exp=%b", k, o_trigger, (k == 3)); end
        end
    endtask

    task automatic test_live_count();
        i_arm = 1'b0;
        tick();
        i_match_count = 8'd5; i_arm = 1'b1; i_data = 8'hA5;
        tick();
        tick();
        checks++; if (o_trigger !== 1'b0) begin errors++; $display("FAIL live_early0 got=%b exp=0", o_trigger); end
        tick();
        checks++; if (o_trigger !== 1'b0) begin errors++; $display("FAIL live_early1 got=%b exp=0", o_trigger); end
        i_match_count = 8'd2;
        tick();
        checks++; if (o_trigger !== 1'b1) begin errors++; $display("FAIL live_lowered got=%b exp=1", o_trigger); end
    endtask

    task automatic test_back_to_back();
        i_match_count = 8'd0; i_data = 8'hA5;
        tick();
        checks++; if (o_trigger !== 1'b0) begin errors++; $display("FAIL rearm_hold_trigger got=%b exp=0", o_trigger); end
        checks++; if (o_armed !== 1'b0) begin errors++; $display("FAIL rearm_hold_armed got=%b exp=0", o_armed); end
        i_arm = 1'b0;
        tick();
        checks++; if (o_armed !== 1'b0) begin errors++; $display("FAIL rearm_idle got=%b exp=0", o_armed); end
        i_arm = 1'b1;
        tick();
        checks++; if (o_armed !== 1'b1) begin errors++; $display("FAIL rearm_armed got=%b exp=1", o_armed); end
        checks++; if (o_trigger !== 1'b0) begin errors++; $display("FAIL rearm_quiet got=%b exp=0", o_trigger); end
        tick();
        checks++; if (o_trigger !== 1'b1) begin errors++; $display("FAIL rearm_trigger got=%b exp=1", o_trigger); end
        checks++; if (o_armed !== 1'b0) begin errors++; $display("FAIL rearm_fired got=%b exp=0", o_armed); end
        tick();
        checks++; if (o_trigger !== 1'b0) begin errors++; $display("FAIL rearm_single got=%b exp=0", o_trigger); end
    endtask

    initial begin
        test_reset();
        test_single_match();
        test_run_length();
        test_priming();
        test_edge();
        test_reset_mid();
        test_live_count();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
